vga_digit_glyph: RTL

- Draws one decimal digit (0-9) as a seven-segment outline on the VGA raster, with programmable position and optional blinking.
- Sits alongside the other glyph/overlay blocks: it receives the pixel coordinates that drive the display and contributes one bit to the overlay OR-tree.
- New configuration arrives over a valid/ready handshake and takes effect only at the start of a frame, so a glyph is never torn mid-frame.
- Output is registered with a fixed 2-cycle latency.

---
 rtl/vga_glyph_pkg.sv | 38 +++
 rtl/vga_digit_glyph_if.sv | 22 ++
 rtl/glyph_segment_hit.sv | 55 +++++
 rtl/vga_digit_glyph.sv | 109 ++++++++++
 4 files changed

// File: rtl/vga_glyph_pkg.sv
// Shared types and segment encoding for the seven-segment glyph overlay.
// Segment bit i of a mask corresponds to segment index SEG_A..SEG_G.
package vga_glyph_pkg;

    typedef logic [11:0] coord_t;
    typedef logic [3:0]  digit_t;
    typedef logic [6:0]  seg_mask_t;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam digit_t DIGIT_BLANK = 4'hF;

    // Bit order of each literal is {g, f, e, d, c, b, a}.
    function automatic seg_mask_t digit_to_seg(input digit_t digit);
        seg_mask_t mask;
        case (digit)
            4'd0:    mask = 7'b0111111;
            4'd1:    mask = 7'b0000110;
            4'd2:    mask = 7'b1011011;
            4'd3:    mask = 7'b1001111;
            4'd4:    mask = 7'b1100110;
            4'd5:    mask = 7'b1101101;
            4'd6:    mask = 7'b1111101;
            4'd7:    mask = 7'b0000111;
            4'd8:    mask = 7'b1111111;
            4'd9:    mask = 7'b1101111;
            default: mask = 7'b0000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/vga_digit_glyph_if.sv
// Configuration channel for the digit glyph: valid/ready with position, digit and blink.
interface vga_digit_glyph_if;
    import vga_glyph_pkg::*;

    logic   cfg_valid;
    logic   cfg_ready;
    coord_t cfg_x;
    coord_t cfg_y;
    digit_t cfg_digit;
    logic   cfg_blink;

    modport master (
        output cfg_valid, cfg_x, cfg_y, cfg_digit, cfg_blink,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_x, cfg_y, cfg_digit, cfg_blink,
        output cfg_ready
    );

endinterface

// File: rtl/glyph_segment_hit.sv
// Combinational hit test of one pixel against the seven stroke rectangles of a glyph box.
// All arithmetic is 13 bits wide so boxes near the 4095 edge clip instead of wrapping.
module glyph_segment_hit
    import vga_glyph_pkg::*;
#(
    parameter int unsigned HORI_LEN = 20,
    parameter int unsigned VERT_LEN = 40,
    parameter int unsigned THICK    = 1
) (
    input  coord_t    i_horz,
    input  coord_t    i_vert,
    input  coord_t    i_x0,
    input  coord_t    i_y0,
    output seg_mask_t o_hits
);

    localparam logic [12:0] HL      = 13'(HORI_LEN);
    localparam logic [12:0] VL      = 13'(VERT_LEN);
    localparam logic [12:0] VL_HALF = 13'(VERT_LEN / 2);
    localparam logic [12:0] THK_M1  = 13'(THICK - 1);

    logic [12:0] w_h, w_v, w_x0, w_y0, w_x1, w_ymid, w_y1;
    logic        w_hspan, w_upper, w_lower, w_col_l, w_col_r;

    function automatic logic in_band(input logic [12:0] p, input logic [12:0] start);
        return (p >= start) && (p <= start + THK_M1);
    endfunction

    assign w_h    = {1'b0, i_horz};
    assign w_v    = {1'b0, i_vert};
    assign w_x0   = {1'b0, i_x0};
    assign w_y0   = {1'b0, i_y0};
    assign w_x1   = w_x0 + HL;
    assign w_ymid = w_y0 + VL_HALF;
    assign w_y1   = w_y0 + VL;

    // Horizontal strokes exclude the corner columns; vertical strokes exclude the stroke rows.
    assign w_hspan = (w_h > w_x0) && (w_h < w_x1);
    assign w_upper = (w_v > w_y0) && (w_v < w_ymid);
    assign w_lower = (w_v > w_ymid) && (w_v < w_y1);
    assign w_col_l = in_band(w_h, w_x0);
    assign w_col_r = in_band(w_h, w_x1);

    always_comb begin
        o_hits        = '0;
        o_hits[SEG_A] = in_band(w_v, w_y0) && w_hspan;
        o_hits[SEG_G] = in_band(w_v, w_ymid) && w_hspan;
        o_hits[SEG_D] = in_band(w_v, w_y1) && w_hspan;
        o_hits[SEG_F] = w_col_l && w_upper;
        o_hits[SEG_E] = w_col_l && w_lower;
        o_hits[SEG_B] = w_col_r && w_upper;
        o_hits[SEG_C] = w_col_r && w_lower;
    end

endmodule

// File: rtl/vga_digit_glyph.sv
// Seven-segment digit overlay: frame-synchronous configuration update, shared blink
// phase, and a two-stage registered pixel output.
module vga_digit_glyph
    import vga_glyph_pkg::*;
#(
    parameter int unsigned DEF_X        = 85,
    parameter int unsigned DEF_Y        = 150,
    parameter int unsigned HORI_LEN     = 20,
    parameter int unsigned VERT_LEN     = 40,
    parameter int unsigned THICK        = 1,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic             CLK_VGA,
    input  logic             RST_N,
    input  coord_t           VGA_horzCoord,
    input  coord_t           VGA_vertCoord,
    vga_digit_glyph_if.slave cfg,
    output logic             OUTPUT
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    coord_t           r_act_x, r_act_y, r_sh_x, r_sh_y;
    digit_t           r_act_digit, r_sh_digit;
    logic             r_act_blink, r_sh_blink;
    logic             r_pending;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_phase;
    seg_mask_t        r_hits;
    logic             r_blank;

    seg_mask_t w_hits;
    logic      w_frame_start;
    logic      w_accept;

    assign w_frame_start = (VGA_horzCoord == '0) && (VGA_vertCoord == '0);
    assign w_accept      = cfg.cfg_valid && !r_pending;
    assign cfg.cfg_ready = ~r_pending;

    glyph_segment_hit #(
        .HORI_LEN (HORI_LEN),
        .VERT_LEN (VERT_LEN),
        .THICK    (THICK)
    ) u_hit (
        .i_horz (VGA_horzCoord),
        .i_vert (VGA_vertCoord),
        .i_x0   (r_act_x),
        .i_y0   (r_act_y),
        .o_hits (w_hits)
    );

    // Shadow loads on accept; active copies the shadow only on the frame-start edge.
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            r_act_x     <= 12'(DEF_X);
            r_act_y     <= 12'(DEF_Y);
            r_act_digit <= DIGIT_BLANK;
            r_act_blink <= 1'b0;
            r_sh_x      <= 12'(DEF_X);
            r_sh_y      <= 12'(DEF_Y);
            r_sh_digit  <= DIGIT_BLANK;
            r_sh_blink  <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (w_frame_start && r_pending) begin
                r_act_x     <= r_sh_x;
                r_act_y     <= r_sh_y;
                r_act_digit <= r_sh_digit;
                r_act_blink <= r_sh_blink;
            end
            if (w_accept) begin
                r_sh_x     <= cfg.cfg_x;
                r_sh_y     <= cfg.cfg_y;
                r_sh_digit <= cfg.cfg_digit;
                r_sh_blink <= cfg.cfg_blink;
            end
            r_pending <= w_accept | (r_pending & ~w_frame_start);
        end
    end

    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_frame_start) begin
            if (r_frame_cnt == CNT_LAST) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    // Mask and blank are captured with the hits so each pixel sees one consistent config.
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            r_hits  <= '0;
            r_blank <= 1'b0;
            OUTPUT  <= 1'b0;
        end else begin
            r_hits  <= w_hits & digit_to_seg(r_act_digit);
            r_blank <= r_act_blink & r_phase;
            OUTPUT  <= (|r_hits) & ~r_blank;
        end
    end

endmodule
